// File: rtl/stepper_phase_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stepper_phase_decoder_if : phase input / decoded-motion bundle  (rev 1.0)
// ---------------------------------------------------------------------------
interface stepper_phase_decoder_if #(
   parameter int POS_W = 12
);
   logic [3:0]       signal;
   logic             pos_clr;
   logic [POS_W-1:0] position;
   logic             dir;
   logic             step_pulse;
   logic             idle;
   logic             stalled;
   logic             err_pulse;
   logic [7:0]       err_count;
   logic [9:0]       stroke_count;

   modport master (
      output signal, pos_clr,
      input  position, dir, step_pulse, idle, stalled,
             err_pulse, err_count, stroke_count
   );

   modport slave (
      input  signal, pos_clr,
      output position, dir, step_pulse, idle, stalled,
             err_pulse, err_count, stroke_count
   );
endinterface
`default_nettype wire

// File: rtl/stepper_phase_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stepper_phase_decoder : one-hot phase pattern to position/dir/stroke/stall
// rev 1.0
// ---------------------------------------------------------------------------
module stepper_phase_decoder #(
   parameter int POS_W   = 12,
   parameter int TIMEOUT = 2097152,
   parameter int TO_W    = 22
) (
   input  logic                    clk,
   input  logic                    rst,
   stepper_phase_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_ERROR  = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] STALL_MAX = '1;
   localparam logic [TO_W-1:0] STALL_LIM = TO_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [3:0]       sig_q, sig_d;
   logic [3:0]       last_q, last_d;
   logic [POS_W-1:0] position_q, position_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [9:0]       stroke_q, stroke_d;
   logic [TO_W-1:0]  stall_q, stall_d;

   // {legal, index} for a one-hot phase pattern
   function automatic logic [2:0] phase_idx(input logic [3:0] p);
      case (p)
         4'b0001: phase_idx = 3'b100;
         4'b0010: phase_idx = 3'b101;
         4'b0100: phase_idx = 3'b110;
         4'b1000: phase_idx = 3'b111;
         default: phase_idx = 3'b000;
      endcase
   endfunction

   logic       change;
   logic [2:0] cur, prev;
   logic       go_err, do_step, step_dir;

   always_comb begin
      sig_d       = bus.signal;
      last_d      = sig_q;
      state_d     = state_q;
      position_d  = position_q;
      dir_d       = dir_q;
      step_d      = 1'b0;
      err_d       = 1'b0;
      err_count_d = err_count_q;
      stroke_d    = stroke_q;
      stall_d     = '0;
      go_err      = 1'b0;
      do_step     = 1'b0;
      step_dir    = 1'b0;
      change      = (sig_q != last_q);
      cur         = phase_idx(sig_q);
      prev        = phase_idx(last_q);

      case (state_q)
         S_IDLE: begin
            if (change) begin
               if (sig_q == 4'b0001)
                  state_d = S_ACTIVE;
               else if (sig_q != 4'b0000)
                  go_err = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!change) begin
               stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + TO_W'(1);
            end else if (sig_q == 4'b0000) begin
               state_d = S_IDLE;
            end else if (cur[2] && (cur[1:0] == prev[1:0] - 2'd1)) begin
               do_step  = 1'b1;
               step_dir = 1'b0;
            end else if (cur[2] && (cur[1:0] == prev[1:0] + 2'd1)) begin
               do_step  = 1'b1;
               step_dir = 1'b1;
            end else begin
               go_err = 1'b1;
            end
         end
         S_ERROR: begin
            if (sig_q == 4'b0000)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (go_err) begin
         state_d     = S_ERROR;
         err_d       = 1'b1;
         err_count_d = (err_count_q == 8'd255) ? err_count_q : err_count_q + 8'd1;
      end

      if (do_step) begin
         step_d     = 1'b1;
         dir_d      = step_dir;
         position_d = step_dir ? position_q - POS_W'(1) : position_q + POS_W'(1);
         // a stroke completes on the first up-step after a down-step
         if (step_dir && !dir_q)
            stroke_d = stroke_q + 10'd1;
      end

      if (bus.pos_clr) begin
         position_d = '0;
         stroke_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sig_q       <= 4'b0000;
         last_q      <= 4'b0000;
         position_q  <= '0;
         dir_q       <= 1'b0;
         step_q      <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
         stroke_q    <= 10'd0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_d;
         last_q      <= last_d;
         position_q  <= position_d;
         dir_q       <= dir_d;
         step_q      <= step_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         stroke_q    <= stroke_d;
         stall_q     <= stall_d;
      end
   end

   assign bus.position     = position_q;
   assign bus.dir          = dir_q;
   assign bus.step_pulse   = step_q;
   assign bus.idle         = (state_q == S_IDLE);
   assign bus.stalled      = (state_q == S_ACTIVE) && (stall_q >= STALL_LIM);
   assign bus.err_pulse    = err_q;
   assign bus.err_count    = err_count_q;
   assign bus.stroke_count = stroke_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stepper_phase_decoder : directed vectors for stepper_phase_decoder (rev 1.0)
// ---------------------------------------------------------------------------
module tb_stepper_phase_decoder;

   localparam int POS_W   = 4;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 6;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   stepper_phase_decoder_if #(.POS_W(POS_W)) bus ();

   stepper_phase_decoder #(
      .POS_W   (POS_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drive a pattern and wait until its decode is visible on the outputs
   task automatic apply(input logic [3:0] v);
      bus.signal = v;
      tick(2);
   endtask

   logic [3:0] fwd [4];

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      rst         = 1'b0;
      bus.signal  = 4'b0000;
      bus.pos_clr = 1'b0;
      fwd[0] = 4'b0010; fwd[1] = 4'b0001; fwd[2] = 4'b1000; fwd[3] = 4'b0100;

      // reset state
      tick(3);
      check_vec("rst_idle",   32'(bus.idle),         32'd1);
      check_vec("rst_pos",    32'(bus.position),     32'd0);
      check_vec("rst_step",   32'(bus.step_pulse),   32'd0);
      check_vec("rst_err",    32'(bus.err_count),    32'd0);
      check_vec("rst_stroke", 32'(bus.stroke_count), 32'd0);
      check_vec("rst_stall",  32'(bus.stalled),      32'd0);
      rst = 1'b1;
      tick(1);

      // entry: idle falls two edges after the pattern appears
      bus.signal = 4'b0001;
      tick(1);
      check_vec("entry_idle_k",  32'(bus.idle), 32'd1);
      tick(1);
      check_vec("entry_idle_k1", 32'(bus.idle), 32'd0);
      check_vec("entry_nostep",  32'(bus.step_pulse), 32'd0);
      check_vec("entry_pos",     32'(bus.position),   32'd0);

      // dir=0 sweep
      apply(4'b1000);
      check_vec("sw_step1", 32'(bus.step_pulse), 32'd1);
      check_vec("sw_pos1",  32'(bus.position),   32'd1);
      check_vec("sw_dir1",  32'(bus.dir),        32'd0);
      tick(1);
      check_vec("sw_single", 32'(bus.step_pulse), 32'd0);
      apply(4'b0100);
      check_vec("sw_pos2", 32'(bus.position), 32'd2);
      apply(4'b0010);
      check_vec("sw_pos3", 32'(bus.position), 32'd3);
      apply(4'b0001);
      check_vec("sw_pos4",    32'(bus.position),     32'd4);
      check_vec("sw_stroke0", 32'(bus.stroke_count), 32'd0);
      // reverse
      apply(4'b0010);
      check_vec("rv_step",   32'(bus.step_pulse),   32'd1);
      check_vec("rv_pos3",   32'(bus.position),     32'd3);
      check_vec("rv_dir",    32'(bus.dir),          32'd1);
      check_vec("rv_stroke", 32'(bus.stroke_count), 32'd1);
      apply(4'b0100);
      check_vec("rv_pos2",    32'(bus.position),     32'd2);
      check_vec("rv_stroke1", 32'(bus.stroke_count), 32'd1);

      // back-to-back changes every cycle
      bus.signal = 4'b1000;
      tick(1);
      bus.signal = 4'b0001;
      tick(1);
      check_vec("fast_step1", 32'(bus.step_pulse), 32'd1);
      check_vec("fast_pos1",  32'(bus.position),   32'd1);
      tick(1);
      check_vec("fast_step2",  32'(bus.step_pulse),   32'd1);
      check_vec("fast_pos0",   32'(bus.position),     32'd0);
      check_vec("fast_stroke", 32'(bus.stroke_count), 32'd1);

      // opposite-phase jump
      apply(4'b0100);
      check_vec("opp_errp",  32'(bus.err_pulse), 32'd1);
      check_vec("opp_errc",  32'(bus.err_count), 32'd1);
      check_vec("opp_pos",   32'(bus.position),  32'd0);
      check_vec("opp_nostep", 32'(bus.step_pulse), 32'd0);
      tick(1);
      check_vec("opp_errp_single", 32'(bus.err_pulse), 32'd0);
      apply(4'b0110);
      check_vec("err_again_p", 32'(bus.err_pulse), 32'd0);
      check_vec("err_again_c", 32'(bus.err_count), 32'd1);
      check_vec("err_idle0",   32'(bus.idle),      32'd0);
      apply(4'b0000);
      check_vec("err_exit_idle", 32'(bus.idle), 32'd1);

      // stall
      apply(4'b0001);
      check_vec("st_active", 32'(bus.idle), 32'd0);
      tick(15);
      check_vec("st_cnt15", 32'(bus.stalled), 32'd0);
      tick(1);
      check_vec("st_cnt16", 32'(bus.stalled), 32'd1);
      tick(4);
      check_vec("st_hold", 32'(bus.stalled), 32'd1);
      bus.signal = 4'b1000;
      tick(1);
      check_vec("st_sampled", 32'(bus.stalled), 32'd1);
      tick(1);
      check_vec("st_fall", 32'(bus.stalled),  32'd0);
      check_vec("st_pos",  32'(bus.position), 32'd1);
      check_vec("st_step", 32'(bus.step_pulse), 32'd1);

      // walk to position 7 then collide a step with pos_clr
      apply(4'b0100);
      apply(4'b0010);
      apply(4'b0001);
      apply(4'b1000);
      apply(4'b0100);
      apply(4'b0010);
      check_vec("clr_pre_pos", 32'(bus.position), 32'd7);
      bus.signal = 4'b0100;
      tick(1);
      bus.pos_clr = 1'b1;
      tick(1);
      bus.pos_clr = 1'b0;
      check_vec("clr_pos",    32'(bus.position),     32'd0);
      check_vec("clr_step",   32'(bus.step_pulse),   32'd1);
      check_vec("clr_dir",    32'(bus.dir),          32'd1);
      check_vec("clr_stroke", 32'(bus.stroke_count), 32'd0);
      check_vec("clr_errc",   32'(bus.err_count),    32'd1);

      // position wrap: 8 dir=0 steps from 0 at 4 bits
      for (int i = 0; i < 8; i++) begin
         apply(fwd[i % 4]);
         if (i == 6) check_vec("wrap_pos7", 32'(bus.position), 32'd7);
      end
      check_vec("wrap_neg8", 32'(bus.position), 32'd8);

      // error-count saturation (one episode already counted)
      apply(4'b0000);
      for (int i = 0; i < 253; i++) begin
         apply(4'b0010);
         apply(4'b0000);
      end
      check_vec("errc_254", 32'(bus.err_count), 32'd254);
      for (int i = 0; i < 3; i++) begin
         apply(4'b0010);
         if (i == 2) check_vec("errp_sat", 32'(bus.err_pulse), 32'd1);
         apply(4'b0000);
      end
      check_vec("errc_sat", 32'(bus.err_count), 32'd255);
      check_vec("err_pos_frozen", 32'(bus.position), 32'd8);

      // reset mid-motion
      apply(4'b0001);
      apply(4'b1000);
      rst = 1'b0;
      tick(2);
      check_vec("rst2_idle", 32'(bus.idle),      32'd1);
      check_vec("rst2_pos",  32'(bus.position),  32'd0);
      check_vec("rst2_errc", 32'(bus.err_count), 32'd0);
      check_vec("rst2_step", 32'(bus.step_pulse), 32'd0);
      rst = 1'b1;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
